// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and widths for the pipeline control unit.
package pipe_ctrl_pkg;

    typedef enum logic {RUN = 1'b0, MUL = 1'b1} state_t;

    localparam int REG_ADDR_W      = 5;
    localparam int STALL_CNT_W     = 16;
    localparam int MUL_LATENCY_DEF = 4;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard compare between ID sources and the EX load target.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    output logic                  o_hazard
);

    logic w_rs_hit;
    logic w_rt_hit;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign w_rs_hit = i_id_uses_rs && (i_id_rs == i_ex_rd);
    assign w_rt_hit = i_id_uses_rt && (i_id_rt == i_ex_rd);
    assign o_hazard = i_ex_mem_read && (i_ex_rd != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: stall/flush control for a 5-stage pipeline with a multi-cycle multiplier.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_mul_start,
    input  logic                   ex_branch_taken,
    input  logic                   mem_busy,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   idex_we,
    output logic                   exmem_we,
    output logic                   memwb_we,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   memwb_flush,
    output logic                   mul_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_count;
    logic                   w_hazard;

    hazard_detect u_hazard (
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rd       (ex_rd),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rs  (id_uses_rs),
        .i_id_uses_rt  (id_uses_rt),
        .o_hazard      (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!pc_we && r_stall_count != '1)
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (reset) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
        end else if (mem_busy) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
            memwb_flush = 1'b1;
        end else if (r_state == MUL) begin
            // cnt==0 is the capture cycle: the product lands in EX/MEM on this edge.
            if (r_cnt != '0) begin
                {pc_we, ifid_we, idex_we} = '0;
                exmem_flush = 1'b1;
                w_cnt_nxt   = r_cnt - 1'b1;
            end else begin
                w_state_nxt = RUN;
            end
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_mul_start) begin
            {pc_we, ifid_we, idex_we} = '0;
            exmem_flush = 1'b1;
            w_state_nxt = MUL;
            w_cnt_nxt   = 4'(MUL_LATENCY - 2);
        end else if (w_hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign mul_busy    = !reset && (r_state == MUL);
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed and randomized checks of pipe_ctrl_unit against a cycle-level reference model.
module tb_pipe_ctrl_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_mul_start, ex_branch_taken, mem_busy;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, mul_busy;
    logic [15:0] stall_count;

    int vectors = 0;
    int errors  = 0;
    int mul_left = 0;
    int sc = 0;
    bit sc_ok = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.MUL_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_mul_start(ex_mul_start), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mul_busy(mul_busy), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {pc,ifid,idex,exmem,memwb}_we, {ifid,idex,exmem,memwb}_flush for the current inputs.
    function automatic logic [8:0] exp_ctl();
        bit hz;
        hz = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        if (reset)             return 9'b00000_1111;
        if (mem_busy)          return 9'b00000_0001;
        if (mul_left > 1)      return 9'b00011_0010;
        if (mul_left == 1)     return 9'b11111_0000;
        if (ex_branch_taken)   return 9'b11111_1100;
        if (ex_mul_start)      return 9'b00011_0010;
        if (hz)                return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    task automatic tick(input string tag);
        logic [8:0] e;
        #1;
        e = exp_ctl();
        check({tag, "_ctl"}, 32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                                  ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'(e));
        check({tag, "_busy"}, 32'(mul_busy), 32'(!reset && mul_left > 0));
        if (sc_ok) check({tag, "_sc"}, 32'(stall_count), 32'(sc));
        @(posedge clk);
        if (reset) begin
            mul_left = 0;
            sc       = 0;
            sc_ok    = 1'b1;
        end else begin
            if (!e[8] && sc < 65535) sc++;
            if (!mem_busy) begin
                if (mul_left > 0) mul_left--;
                else if (!ex_branch_taken && ex_mul_start) mul_left = LAT - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
        ex_mul_start = 0; ex_branch_taken = 0; mem_busy = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clk);
        tick("rst0");
        tick("rst1");
        idle();
        tick("idle");
        ex_mem_read = 1; ex_rd = 7; id_rs = 7; id_uses_rs = 1;
        tick("lu");
        check("lu_sc1", 32'(stall_count), 32'd1);
        ex_rd = 0; id_rs = 0;
        tick("lu_r0");
        check("lu_r0_sc", 32'(stall_count), 32'd1);
        idle();
        ex_mul_start = 1;
        tick("mul_s");
        ex_mul_start = 0;
        for (int i = 0; i < LAT; i++) tick("mul_run");
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1;
        tick("br_lu");
        idle();
        ex_mul_start = 1;
        tick("mb_s");
        idle();
        tick("mb_c2");
        mem_busy = 1;
        tick("mb_h0");
        tick("mb_h1");
        idle();
        tick("mb_c1");
        tick("mb_c0");
        check("mb_done", 32'(mul_busy), 32'd0);
        ex_mul_start = 1;
        tick("rm_s");
        idle();
        reset = 1;
        tick("rm_rst");
        idle();
        check("rm_busy", 32'(mul_busy), 32'd0);
        check("rm_sc", 32'(stall_count), 32'd0);
        tick("rm_after");
        repeat (3000) begin
            reset           = ($urandom_range(99) < 2);
            mem_busy        = ($urandom_range(99) < 15);
            ex_branch_taken = ($urandom_range(99) < 15);
            ex_mul_start    = ($urandom_range(99) < 15);
            ex_mem_read     = ($urandom_range(99) < 40);
            ex_rd           = 5'($urandom_range(3));
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            id_uses_rs      = 1'($urandom_range(1));
            id_uses_rt      = 1'($urandom_range(1));
            tick("rnd");
        end
        idle();
        mem_busy = 1;
        repeat (65540) tick("sat");
        check("sat_sc", 32'(stall_count), 32'hFFFF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter MUL_LATENCY, default 4, total EX-stage cycles for a multiply (legal 2..16).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-006 ex_mem_read  input  1  EX instruction is a load.
REQ-007 ex_rd  input  5  destination register of the EX instruction.
REQ-008 ex_mul_start  input  1  multiply enters EX this cycle; honoured only in RUN.
REQ-009 ex_branch_taken  input  1  EX resolves a taken branch or jump.
REQ-010 mem_busy  input  1  data memory not ready; MEM must hold.
REQ-011 pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  write_enable for PC and each pipeline register.
REQ-012 ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  aload-style bubble insert into each pipeline register.
REQ-013 mul_busy  output  1  high while FSM is in MUL.
REQ-014 stall_count  output  16  saturating count of cycles with pc_we=0.

Function
REQ-015 FSM states: RUN, MUL; 4-bit down-counter cnt.
REQ-016 Control outputs are combinational from registered state/cnt and current inputs; default all *_we=1, all *_flush=0.
REQ-017 Priority, highest first: reset, mem_busy, MUL-state stall, ex_branch_taken, ex_mul_start, load-use.
REQ-018 mem_busy: all *_we=0, memwb_flush=1, all other flushes 0; state and cnt frozen; lower-priority conditions ignored.
REQ-019 Load-use hazard: ex_mem_read && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
REQ-020 Load-use in RUN: pc_we=0, ifid_we=0, idex_flush=1; downstream stages advance.
REQ-021 ex_branch_taken in RUN: pc_we=1, ifid_flush=1, idex_flush=1; any load-use hazard and ex_mul_start in the same cycle are ignored.
REQ-022 ex_mul_start in RUN (no branch): pc_we=ifid_we=idex_we=0, exmem_flush=1; next state MUL, cnt<=MUL_LATENCY-2.
REQ-023 MUL with cnt!=0: same stall outputs as REQ-022; cnt decrements.
REQ-024 MUL with cnt==0: default outputs (EX/MEM captures the product); next state RUN.
REQ-025 A multiply stalls upstream stages for exactly MUL_LATENCY-1 cycles; EX/MEM captures on the MUL_LATENCY-th edge after start.
REQ-026 In MUL, ex_branch_taken, ex_mul_start and load-use are ignored.
REQ-027 stall_count increments on each non-reset cycle with pc_we=0; it holds at 16'hFFFF (no wrap).
REQ-028 mul_busy = (state==MUL).

Reset
REQ-029 While reset=1: all *_we=0, all *_flush=1, mul_busy=0.
REQ-030 On the first edge with reset=1, state<=RUN, cnt<=0 and stall_count<=0, including mid-multiply and mid-mem_busy.
REQ-031 Reset cycles do not increment stall_count.

Structure
REQ-032 Shared package pipe_ctrl_pkg holds the state enum {RUN, MUL}, REG_ADDR_W=5, STALL_CNT_W=16 and the MUL_LATENCY default.
REQ-033 Load-use compare is a combinational sub-module, hazard_detect; FSM, counters and output muxing live in pipe_ctrl_unit.
REQ-034 Outputs connect directly to the pipeline registers' write_enable and aload pins.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rd=7, id_rs=7, id_uses_rs=1 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1, stall_count=1; with ex_rd=0 -> no stall.
REQ-036 Multiply: ex_mul_start pulse, MUL_LATENCY=4 -> 3 cycles pc_we=idex_we=0, exmem_flush=1; 4th cycle all we=1; mul_busy high 3 cycles.
REQ-037 Branch plus load-use in the same cycle -> pc_we=1, ifid_flush=1, idex_flush=1, no stall.
REQ-038 mem_busy=1 for 2 cycles during MUL with cnt=1 -> all we=0, memwb_flush=1; cnt stays 1; multiply completes 2 cycles later.
REQ-039 reset asserted mid-multiply -> next cycle state RUN, mul_busy=0, stall_count=0; during reset all flush=1.
REQ-040 Force 65540 stall cycles -> stall_count=16'hFFFF, no wrap.
